// File: rtl/pipe_run_ctrl.sv
// Run/step/halt sequencer for a 5-stage pipeline: paces pipe_en, drains after the halt word,
// and keeps saturating advance/flush/stall counters plus a frozen retired-instruction count.
module pipe_run_ctrl #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int unsigned PIPE_DEPTH = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_run,
  input  logic             step_req,
  input  logic [31:0]      fetch_inst,
  input  logic             flush,
  input  logic             stall,
  output logic             pipe_en,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(PIPE_DEPTH) + 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0]    DRAIN_LEN = DW'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W+1:0] DRAIN_SUB = (CNT_W + 2)'(PIPE_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [TW-1:0]    tick_r;
  logic [DW-1:0]    drain_r;
  logic             step_q_r;
  logic             step_edge_s;
  logic             tick_last_s;
  logic             halt_hit_s;
  logic [CNT_W-1:0] cycle_nxt_s;
  logic [CNT_W-1:0] flush_nxt_s;
  logic [CNT_W-1:0] stall_nxt_s;
  logic [CNT_W+1:0] retire_calc_s;
  logic [CNT_W-1:0] retire_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  assign state       = state_r;
  assign step_edge_s = step_req & ~step_q_r;
  assign tick_last_s = (tick_r == TICK_LAST);
  assign halt_hit_s  = pipe_en & (fetch_inst == HALT_WORD);

  // Advance enable is decoded straight from state so the pipeline sees it with no added latency.
  always_comb begin
    pipe_en = 1'b0;
    case (state_r)
      S_RUN:   pipe_en = mode_run & tick_last_s;
      S_STEP:  pipe_en = 1'b1;
      S_DRAIN: pipe_en = tick_last_s;
      default: pipe_en = 1'b0;
    endcase
  end

  // Next counter values; the retired count is taken from these so the final drain advance is included.
  always_comb begin
    cycle_nxt_s   = sat_inc(cycle_cnt, pipe_en);
    flush_nxt_s   = sat_inc(flush_cnt, pipe_en & flush);
    stall_nxt_s   = sat_inc(stall_cnt, pipe_en & stall);
    retire_calc_s = {2'b00, cycle_nxt_s} - DRAIN_SUB - {2'b00, flush_nxt_s} - {2'b00, stall_nxt_s};
    if (retire_calc_s[CNT_W+1:CNT_W] != 2'b00) begin
      retire_s = {CNT_W{1'b0}};
    end else begin
      retire_s = retire_calc_s[CNT_W-1:0];
    end
  end

  // Sequencer FSM, tick divider, drain counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      tick_r      <= {TW{1'b0}};
      drain_r     <= {DW{1'b0}};
      step_q_r    <= 1'b0;
      halted      <= 1'b0;
      cycle_cnt   <= {CNT_W{1'b0}};
      flush_cnt   <= {CNT_W{1'b0}};
      stall_cnt   <= {CNT_W{1'b0}};
      retired_cnt <= {CNT_W{1'b0}};
    end else begin
      step_q_r  <= step_req;
      cycle_cnt <= cycle_nxt_s;
      flush_cnt <= flush_nxt_s;
      stall_cnt <= stall_nxt_s;
      case (state_r)
        S_IDLE: begin
          tick_r <= {TW{1'b0}};
          if (mode_run) begin
            state_r <= S_RUN;
          end else if (step_edge_s) begin
            state_r <= S_STEP;
          end
        end
        S_RUN, S_STEP: begin
          if (halt_hit_s) begin
            state_r <= S_DRAIN;
            tick_r  <= {TW{1'b0}};
            drain_r <= DRAIN_LEN;
          end else if ((state_r == S_STEP) || !mode_run) begin
            state_r <= S_IDLE;
            tick_r  <= {TW{1'b0}};
          end else if (tick_last_s) begin
            tick_r <= {TW{1'b0}};
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end
        S_DRAIN: begin
          if (tick_last_s) begin
            tick_r  <= {TW{1'b0}};
            drain_r <= drain_r - DW'(1);
            if (drain_r == DW'(1)) begin
              state_r     <= S_DONE;
              halted      <= 1'b1;
              retired_cnt <= retire_s;
            end
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end
        S_DONE: begin
          halted <= 1'b1;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboard bench for pipe_run_ctrl: a deadline-based reference model predicts every pipe_en
// pulse and halt event; a negedge monitor pops and compares whenever the DUT presents one.
module tb_pipe_run_ctrl;

  localparam int TD   = 4;
  localparam int PD   = 5;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_DONE = 4;

  logic          clk = 1'b0;
  logic          reset, mode_run, step_req, flush, stall;
  logic [31:0]   fetch_inst;
  logic          pipe_en, halted;
  logic [2:0]    state;
  logic [CW-1:0] cycle_cnt, flush_cnt, stall_cnt, retired_cnt;

  pipe_run_ctrl #(.TICK_DIV(TD), .HALT_WORD(HW), .PIPE_DEPTH(PD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mode_run(mode_run), .step_req(step_req),
    .fetch_inst(fetch_inst), .flush(flush), .stall(stall),
    .pipe_en(pipe_en), .halted(halted), .state(state),
    .cycle_cnt(cycle_cnt), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int c; int f; int s; } pulse_t;
  typedef struct { int cyc; int c; int f; int s; int r; } done_t;
  pulse_t pq[$];
  done_t  dq[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: absolute pulse deadlines, drain pulses remaining, saturating counts.
  int md = M_IDLE, due = 0, left = 0, mc = 0, mf = 0, ms = 0;
  bit sp = 1'b0;

  function automatic int sat(input int v, input bit en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model(input int m, input logic rst, mr, sr, input logic [31:0] inst,
                       input logic fl, st);
    bit pulse, stp_edge, hit;
    int nmd, r;
    pulse = 1'b0;
    nmd = md;
    stp_edge = sr && !sp;
    case (md)
      M_IDLE: begin
        if (mr) begin nmd = M_RUN; due = m + TD; end
        else if (stp_edge) nmd = M_STEP;
      end
      M_RUN:   pulse = mr && (m == due);
      M_STEP:  pulse = 1'b1;
      M_DRAIN: pulse = (m == due);
      default: pulse = 1'b0;
    endcase
    hit = pulse && (inst == HW);
    if (md == M_RUN || md == M_STEP) begin
      if (hit) begin nmd = M_DRAIN; due = m + TD; left = PD - 1; end
      else if (md == M_STEP || !mr) nmd = M_IDLE;
      else if (pulse) due = m + TD;
    end else if (md == M_DRAIN && pulse) begin
      left--;
      due = m + TD;
      if (left == 0) nmd = M_DONE;
    end
    if (pulse) begin
      pq.push_back('{m, mc, mf, ms});
      mc = sat(mc, 1'b1);
      mf = sat(mf, fl);
      ms = sat(ms, st);
    end
    if (rst) begin
      md = M_IDLE; sp = 1'b0; mc = 0; mf = 0; ms = 0;
    end else begin
      if (nmd == M_DONE && md != M_DONE) begin
        r = mc - (PD - 1) - mf - ms;
        if (r < 0) r = 0;
        dq.push_back('{m + 1, mc, mf, ms, r});
      end
      md = nmd;
      sp = sr;
    end
  endtask

  task automatic drive(input logic rst, mr, sr, input logic [31:0] inst, input logic fl, st);
    @(posedge clk);
    #1;
    reset = rst; mode_run = mr; step_req = sr; fetch_inst = inst; flush = fl; stall = st;
    model(cyc, rst, mr, sr, inst, fl, st);
  endtask

  function automatic logic rbit(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] v;
    v = $urandom;
    if (v == HW) v = 32'h0000_0013;
    return v;
  endfunction

  task automatic do_reset();
    repeat (2) drive(1'b1, 1'b0, 1'b0, rnd_inst(), 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, rnd_inst(), 1'b0, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    #1;
    check({tag, "_state"},   int'(state), 0);
    check({tag, "_pipe_en"}, int'(pipe_en), 0);
    check({tag, "_halted"},  int'(halted), 0);
    check({tag, "_cycle"},   int'(cycle_cnt), 0);
    check({tag, "_flush"},   int'(flush_cnt), 0);
    check({tag, "_stall"},   int'(stall_cnt), 0);
    check({tag, "_retired"}, int'(retired_cnt), 0);
  endtask

  // Monitor: each DUT pipe_en pulse or halted rise pops and checks the next expected event.
  pulse_t p;
  done_t  d;
  logic   halted_prev = 1'b0;
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      check("missed_pipe_en_cycle", cyc, pq[0].cyc);
      void'(pq.pop_front());
    end
    while (dq.size() > 0 && dq[0].cyc < cyc) begin
      check("missed_halted_cycle", cyc, dq[0].cyc);
      void'(dq.pop_front());
    end
    if (pipe_en === 1'b1) begin
      if (pq.size() == 0) check("unexpected_pipe_en_cycle", cyc, -1);
      else begin
        p = pq.pop_front();
        check("pulse_cycle", cyc, p.cyc);
        check("pulse_cycle_cnt", int'(cycle_cnt), p.c);
        check("pulse_flush_cnt", int'(flush_cnt), p.f);
        check("pulse_stall_cnt", int'(stall_cnt), p.s);
      end
    end
    if (halted === 1'b1 && halted_prev !== 1'b1) begin
      if (dq.size() == 0) check("unexpected_halted_cycle", cyc, -1);
      else begin
        d = dq.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("done_cycle_cnt", int'(cycle_cnt), d.c);
        check("done_flush_cnt", int'(flush_cnt), d.f);
        check("done_stall_cnt", int'(stall_cnt), d.s);
        check("done_retired", int'(retired_cnt), d.r);
        check("done_state", int'(state), 4);
      end
    end
    halted_prev = halted;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rmr, rsr;
    rmr = 1'b0; rsr = 1'b0;
    reset = 1'b1; mode_run = 1'b0; step_req = 1'b0; fetch_inst = 32'h0; flush = 1'b0; stall = 1'b0;
    do_reset();
    check_reset("init");

    // 1: reset while running
    repeat (10) drive(1'b0, 1'b1, 1'b0, rnd_inst(), rbit(50), rbit(50));
    check("t1_state_run", int'(state), 1);
    do_reset();
    check_reset("t1");

    // 2: free-run, then pause
    repeat (40) drive(1'b0, 1'b1, 1'b0, rnd_inst(), rbit(40), rbit(40));
    repeat (15) drive(1'b0, 1'b0, 1'b0, rnd_inst(), rbit(40), rbit(40));
    check("t2_cycle_frozen", int'(cycle_cnt), 9);
    check("t2_state_idle", int'(state), 0);

    // 3: step on rising edges only
    do_reset();
    repeat (10) drive(1'b0, 1'b0, 1'b1, rnd_inst(), 1'b0, 1'b0);
    repeat (3)  drive(1'b0, 1'b0, 1'b0, rnd_inst(), 1'b0, 1'b0);
    check("t3_one_step", int'(cycle_cnt), 1);
    repeat (5)  drive(1'b0, 1'b0, 1'b1, rnd_inst(), 1'b0, 1'b0);
    repeat (3)  drive(1'b0, 1'b0, 1'b0, rnd_inst(), 1'b0, 1'b0);
    check("t3_two_steps", int'(cycle_cnt), 2);

    // 4: halt at 3rd pulse, drain ignores mode/step
    do_reset();
    for (int i = 0; i < 200 && md != M_DONE; i++) begin
      if (md == M_DRAIN) drive(1'b0, rbit(50), rbit(50), HW, 1'b0, 1'b0);
      else drive(1'b0, 1'b1, 1'b0, (mc >= 2) ? HW : rnd_inst(), 1'b0, 1'b0);
    end
    repeat (20) drive(1'b0, rbit(50), rbit(50), HW, rbit(50), rbit(50));
    check("t4_halted", int'(halted), 1);
    check("t4_cycle", int'(cycle_cnt), 7);
    check("t4_retired", int'(retired_cnt), 3);

    // 5: flushes on pulses 2 and 5, stall on pulse 4, halt at pulse 8
    do_reset();
    for (int i = 0; i < 200 && md != M_DONE; i++)
      drive(1'b0, 1'b1, 1'b0, (mc >= 7) ? HW : rnd_inst(), (mc == 1 || mc == 4), (mc == 3));
    repeat (5) drive(1'b0, 1'b0, 1'b0, rnd_inst(), 1'b0, 1'b0);
    check("t5_flush", int'(flush_cnt), 2);
    check("t5_stall", int'(stall_cnt), 1);
    check("t5_cycle", int'(cycle_cnt), 12);
    check("t5_retired", int'(retired_cnt), 5);

    // 6: reset mid-drain, then single-step into a halt with flushes (clamped retire)
    do_reset();
    for (int i = 0; i < 100 && !(md == M_DRAIN && left == 2); i++)
      drive(1'b0, 1'b1, 1'b0, HW, 1'b0, 1'b0);
    check("t6_in_drain", int'(state), 3);
    do_reset();
    check_reset("t6");
    for (int i = 0; i < 100 && md != M_DONE; i++)
      drive(1'b0, 1'b0, 1'b1, HW, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, rnd_inst(), 1'b0, 1'b0);
    check("t6_halted", int'(halted), 1);
    check("t6_flush", int'(flush_cnt), 5);
    check("t6_retired_clamped", int'(retired_cnt), 0);

    // 7: counters saturate, then halt
    do_reset();
    repeat (1100) drive(1'b0, 1'b1, 1'b0, rnd_inst(), rbit(50), rbit(30));
    check("t7_cycle_sat", int'(cycle_cnt), CMAX);
    for (int i = 0; i < 200 && md != M_DONE; i++)
      drive(1'b0, 1'b1, 1'b0, HW, rbit(50), rbit(30));
    repeat (3) drive(1'b0, 1'b0, 1'b0, rnd_inst(), 1'b0, 1'b0);
    check("t7_halted", int'(halted), 1);
    check("t7_cycle_held", int'(cycle_cnt), CMAX);

    // 8: random mix
    do_reset();
    repeat (900) begin
      if (rbit(5)) rmr = !rmr;
      if (rbit(15)) rsr = !rsr;
      drive(rbit(1) || (md == M_DONE && rbit(10)), rmr, rsr,
            rbit(10) ? HW : rnd_inst(), rbit(30), rbit(30));
    end
    repeat (8) drive(1'b0, 1'b0, 1'b0, rnd_inst(), 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("pending_pulses", pq.size(), 0);
    check("pending_done", dq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
